regfile_operand_fetch: RTL and testbench

- Read-side sequencer between decode and the ALU.
- Accepts one issue request (two sources, destination, write_sel), stalls while either source has an outstanding ALU write, then reads both operands from the synchronous-read register file.
- Presents the operands to the ALU over a valid/ready handshake.
- Tracks pending writes in a per-register scoreboard, cleared by the ALU writeback port.

---
 rtl/regfile_alu_shared_pkg.sv | 11 +
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_scoreboard.sv | 42 ++++
 rtl/regfile_operand_fetch.sv | 155 +++++++++++++++
 tb/tb_regfile_operand_fetch.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_alu_shared_pkg.sv
// Types shared between the register file, the operand fetch unit and the ALU.
package regfile_alu_shared_pkg;

    typedef enum logic [1:0] {
        WSEL_NONE = 2'd0,
        WSEL_REGC = 2'd1,
        WSEL_REGF = 2'd2,
        WSEL_RFU  = 2'd3
    } write_sel_t;

endpackage

// File: rtl/regfile_pkg.sv
// Register-file constants and operand fetch state encoding.
package regfile_pkg;

    localparam int RF_REGISTERS = 8;
    localparam int FLAGS_INDEX  = 7;   // R_F, the flags register

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_READ  = 2'd2,
        S_OUT   = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write vector; set has priority over clear, bit 0 never pends.
module regfile_scoreboard #(
    parameter int REGISTERS   = 8,
    parameter int INDEX_WIDTH = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   set_en,
    input  logic [INDEX_WIDTH-1:0] set_idx,
    input  logic                   clr_en,
    input  logic [INDEX_WIDTH-1:0] clr_idx,
    input  logic [INDEX_WIDTH-1:0] rd_idx_a,
    input  logic [INDEX_WIDTH-1:0] rd_idx_b,
    output logic                   pend_a,
    output logic                   pend_b
);

    localparam logic [REGISTERS-1:0] KEEP_MASK = {{(REGISTERS-1){1'b1}}, 1'b0};

    logic [REGISTERS-1:0] pend_q;
    logic [REGISTERS-1:0] set_mask;
    logic [REGISTERS-1:0] clr_mask;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_en) set_mask[set_idx] = 1'b1;
        if (clr_en) clr_mask[clr_idx] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= '0;
        end else begin
            pend_q <= ((pend_q & ~clr_mask) | set_mask) & KEEP_MASK;
        end
    end

    assign pend_a = pend_q[rd_idx_a];
    assign pend_b = pend_q[rd_idx_b];

endmodule

// File: rtl/regfile_operand_fetch.sv
// Operand fetch sequencer: hazard stall on pending writes, sync regfile read, valid/ready to ALU.
// Optional REGFILE_WB_BYPASS_EN: same-cycle writeback masks the hazard and forwards i_wb_data.
//
//   state   | meaning
//   S_IDLE  | ready for an issue request
//   S_CHECK | waiting for both sources to be free; drives read addresses when clear
//   S_READ  | register file data arriving; capture operands, mark destination pending
//   S_OUT   | operands presented to the ALU until accepted
module regfile_operand_fetch
    import regfile_pkg::*;
    import regfile_alu_shared_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int REGISTERS   = RF_REGISTERS,
    parameter int INDEX_WIDTH = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [INDEX_WIDTH-1:0] i_srca,
    input  logic [INDEX_WIDTH-1:0] i_srcb,
    input  logic [INDEX_WIDTH-1:0] i_dest,
    input  logic [1:0]             i_wsel,
    output logic [INDEX_WIDTH-1:0] o_rd_addr_a,
    output logic [INDEX_WIDTH-1:0] o_rd_addr_b,
    input  logic [DATA_WIDTH-1:0]  i_rd_data_a,
    input  logic [DATA_WIDTH-1:0]  i_rd_data_b,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [DATA_WIDTH-1:0]  o_op_a,
    output logic [DATA_WIDTH-1:0]  o_op_b,
    output logic [INDEX_WIDTH-1:0] o_dest,
    output logic [1:0]             o_wsel,
    input  logic                   i_wb_valid,
    input  logic [1:0]             i_wb_wsel,
    input  logic [INDEX_WIDTH-1:0] i_wb_dest,
    input  logic [DATA_WIDTH-1:0]  i_wb_data,
    output logic                   o_err
);

    localparam logic [INDEX_WIDTH-1:0] FLAGS_IDX = INDEX_WIDTH'(FLAGS_INDEX);

    fetch_state_t           state_q, state_d;
    logic [INDEX_WIDTH-1:0] srca_q, srcb_q, dest_q;
    write_sel_t             wsel_q, wb_wsel;
    logic [DATA_WIDTH-1:0]  op_a_q, op_b_q;
    logic [DATA_WIDTH-1:0]  rd_a_val, rd_b_val;
    logic                   valid_q, err_q;
    logic                   accept, hazard, pend_a, pend_b, hz_a, hz_b;
    logic                   set_en, wb_clr_en, wb_hit_a, wb_hit_b;
    logic [INDEX_WIDTH-1:0] set_idx, wb_clr_idx;

    assign wb_wsel    = write_sel_t'(i_wb_wsel);
    assign wb_clr_en  = i_wb_valid &&
                        ((wb_wsel == WSEL_REGC && i_wb_dest != '0) || wb_wsel == WSEL_REGF);
    assign wb_clr_idx = (wb_wsel == WSEL_REGF) ? FLAGS_IDX : i_wb_dest;
    assign wb_hit_a   = wb_clr_en && (wb_clr_idx == srca_q) && (srca_q != '0);
    assign wb_hit_b   = wb_clr_en && (wb_clr_idx == srcb_q) && (srcb_q != '0);

    assign set_en  = (state_q == S_READ) &&
                     ((wsel_q == WSEL_REGC && dest_q != '0) || wsel_q == WSEL_REGF);
    assign set_idx = (wsel_q == WSEL_REGF) ? FLAGS_IDX : dest_q;

    regfile_scoreboard #(
        .REGISTERS   (REGISTERS),
        .INDEX_WIDTH (INDEX_WIDTH)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .set_en   (set_en),
        .set_idx  (set_idx),
        .clr_en   (wb_clr_en),
        .clr_idx  (wb_clr_idx),
        .rd_idx_a (srca_q),
        .rd_idx_b (srcb_q),
        .pend_a   (pend_a),
        .pend_b   (pend_b)
    );

`ifdef REGFILE_WB_BYPASS_EN
    assign hz_a     = pend_a && !wb_hit_a;
    assign hz_b     = pend_b && !wb_hit_b;
    assign rd_a_val = (srca_q == '0) ? '0 : (wb_hit_a ? i_wb_data : i_rd_data_a);
    assign rd_b_val = (srcb_q == '0) ? '0 : (wb_hit_b ? i_wb_data : i_rd_data_b);
`else
    logic unused_wb;
    assign unused_wb = ^{i_wb_data, wb_hit_a, wb_hit_b};
    assign hz_a      = pend_a;
    assign hz_b      = pend_b;
    assign rd_a_val  = (srca_q == '0) ? '0 : i_rd_data_a;
    assign rd_b_val  = (srcb_q == '0) ? '0 : i_rd_data_b;
`endif

    assign hazard  = hz_a || hz_b;
    assign o_ready = (state_q == S_IDLE) && !rst;
    assign accept  = (state_q == S_IDLE) && i_valid;

    always_comb begin
        state_d     = state_q;
        o_rd_addr_a = '0;
        o_rd_addr_b = '0;
        case (state_q)
            S_IDLE:  if (i_valid) state_d = S_CHECK;
            S_CHECK: begin
                if (!hazard) begin
                    o_rd_addr_a = srca_q;
                    o_rd_addr_b = srcb_q;
                    state_d     = S_READ;
                end
            end
            S_READ:  state_d = S_OUT;
            S_OUT:   if (i_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            srca_q  <= '0;
            srcb_q  <= '0;
            dest_q  <= '0;
            wsel_q  <= WSEL_NONE;
            op_a_q  <= '0;
            op_b_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= accept && (write_sel_t'(i_wsel) == WSEL_RFU);
            if (accept) begin
                srca_q <= i_srca;
                srcb_q <= i_srcb;
                dest_q <= i_dest;
                wsel_q <= write_sel_t'(i_wsel);
            end
            if (state_q == S_READ) begin
                op_a_q  <= rd_a_val;
                op_b_q  <= rd_b_val;
                valid_q <= 1'b1;
            end else if (state_q == S_OUT && i_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign o_valid = valid_q;
    assign o_op_a  = op_a_q;
    assign o_op_b  = op_b_q;
    assign o_dest  = dest_q;
    assign o_wsel  = wsel_q;
    assign o_err   = err_q;

endmodule

// File: tb/tb_regfile_operand_fetch.sv
// Directed self-checking bench for regfile_operand_fetch with a synchronous-read register file model.
module tb_regfile_operand_fetch;
    import regfile_alu_shared_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic        o_ready;
    logic [2:0]  i_srca, i_srcb, i_dest;
    logic [1:0]  i_wsel;
    logic [2:0]  o_rd_addr_a, o_rd_addr_b;
    logic [15:0] i_rd_data_a, i_rd_data_b;
    logic        o_valid;
    logic        i_ready;
    logic [15:0] o_op_a, o_op_b;
    logic [2:0]  o_dest;
    logic [1:0]  o_wsel;
    logic        i_wb_valid;
    logic [1:0]  i_wb_wsel;
    logic [2:0]  i_wb_dest;
    logic [15:0] i_wb_data;
    logic        o_err;

    logic [15:0] rf [8];
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        i_rd_data_a <= rf[o_rd_addr_a];
        i_rd_data_b <= rf[o_rd_addr_b];
    end

    regfile_operand_fetch dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_srca(i_srca), .i_srcb(i_srcb), .i_dest(i_dest), .i_wsel(i_wsel),
        .o_rd_addr_a(o_rd_addr_a), .o_rd_addr_b(o_rd_addr_b),
        .i_rd_data_a(i_rd_data_a), .i_rd_data_b(i_rd_data_b),
        .o_valid(o_valid), .i_ready(i_ready), .o_op_a(o_op_a), .o_op_b(o_op_b),
        .o_dest(o_dest), .o_wsel(o_wsel), .i_wb_valid(i_wb_valid),
        .i_wb_wsel(i_wb_wsel), .i_wb_dest(i_wb_dest), .i_wb_data(i_wb_data),
        .o_err(o_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one issue; returns one cycle after acceptance (first S_CHECK cycle).
    task automatic issue(input logic [2:0] a, input logic [2:0] b, input logic [2:0] d,
                         input write_sel_t w);
        int k = 0;
        while (!o_ready && k < 20) begin tick(); k++; end
        n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL issue_ready: o_ready=%0b want 1", o_ready); end
        i_srca = a; i_srcb = b; i_dest = d; i_wsel = w; i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
    endtask

    task automatic wait_valid();
        int k = 0;
        while (o_valid !== 1'b1 && k < 20) begin tick(); k++; end
        n_checks++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL wait_valid: timed out, o_valid=%0b want 1", o_valid); end
    endtask

    task automatic writeback(input write_sel_t w, input logic [2:0] d, input logic [15:0] data);
        i_wb_valid = 1'b1; i_wb_wsel = w; i_wb_dest = d; i_wb_data = data;
    endtask

    task automatic wb_idle();
        i_wb_valid = 1'b0; i_wb_wsel = WSEL_NONE; i_wb_dest = 3'd0; i_wb_data = 16'h0;
    endtask

    task automatic test_reset();
        rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
        i_srca = 3'd0; i_srcb = 3'd0; i_dest = 3'd0; i_wsel = WSEL_NONE;
        wb_idle();
        tick(); tick();
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: o_valid=%0b want 0", o_valid); end
        n_checks++; if (o_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: o_ready=%0b want 0", o_ready); end
        n_checks++; if ({o_op_a, o_op_b} !== 32'h0) begin n_fail++; $display("FAIL rst_ops: a=%h b=%h want 0", o_op_a, o_op_b); end
        n_checks++; if (o_dest !== 3'd0 || o_wsel !== WSEL_NONE || o_err !== 1'b0) begin n_fail++; $display("FAIL rst_misc: dest=%0d wsel=%0d err=%0b want 0/0/0", o_dest, o_wsel, o_err); end
        n_checks++; if ({o_rd_addr_a, o_rd_addr_b} !== 6'd0) begin n_fail++; $display("FAIL rst_addr: a=%0d b=%0d want 0", o_rd_addr_a, o_rd_addr_b); end
        n_checks++; if (dut.u_scoreboard.pend_q !== 8'h00) begin n_fail++; $display("FAIL rst_pend: pend=%b want 0", dut.u_scoreboard.pend_q); end
        rst = 1'b0;
        tick();
        n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: o_ready=%0b want 1", o_ready); end
    endtask

    task automatic test_basic();
        issue(3'd1, 3'd2, 3'd3, WSEL_REGC);
        n_checks++; if (o_rd_addr_a !== 3'd1 || o_rd_addr_b !== 3'd2) begin n_fail++; $display("FAIL basic_addr: a=%0d b=%0d want 1/2", o_rd_addr_a, o_rd_addr_b); end
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_n1: o_valid=%0b want 0", o_valid); end
        tick();
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_n2: o_valid=%0b want 0", o_valid); end
        tick();
        n_checks++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL basic_latency: o_valid=%0b want 1 at N+3", o_valid); end
        n_checks++; if (o_op_a !== 16'h0011 || o_op_b !== 16'h0022) begin n_fail++; $display("FAIL basic_ops: a=%h b=%h want 0011/0022", o_op_a, o_op_b); end
        n_checks++; if (o_dest !== 3'd3 || o_wsel !== WSEL_REGC) begin n_fail++; $display("FAIL basic_dest: dest=%0d wsel=%0d want 3/1", o_dest, o_wsel); end
        n_checks++; if (dut.u_scoreboard.pend_q !== 8'h08) begin n_fail++; $display("FAIL basic_pend: pend=%b want 00001000", dut.u_scoreboard.pend_q); end
        tick();
        n_checks++; if (o_valid !== 1'b0 || o_ready !== 1'b1) begin n_fail++; $display("FAIL basic_done: valid=%0b ready=%0b want 0/1", o_valid, o_ready); end
    endtask

    task automatic test_hazard_regc();
        issue(3'd3, 3'd1, 3'd5, WSEL_NONE);
        n_checks++; if (o_rd_addr_a !== 3'd0) begin n_fail++; $display("FAIL haz_stall_addr: a=%0d want 0", o_rd_addr_a); end
        tick(); tick();
        n_checks++; if (o_rd_addr_a !== 3'd0 || o_valid !== 1'b0) begin n_fail++; $display("FAIL haz_still_stalled: a=%0d valid=%0b want 0/0", o_rd_addr_a, o_valid); end
        writeback(WSEL_REGC, 3'd3, 16'h1234);
        #1;
`ifdef REGFILE_WB_BYPASS_EN
        n_checks++; if (o_rd_addr_a !== 3'd3) begin n_fail++; $display("FAIL haz_release_M: a=%0d want 3", o_rd_addr_a); end
`else
        n_checks++; if (o_rd_addr_a !== 3'd0) begin n_fail++; $display("FAIL haz_release_M: a=%0d want 0", o_rd_addr_a); end
`endif
        tick();
        wb_idle();
        #1;
`ifdef REGFILE_WB_BYPASS_EN
        n_checks++; if (o_rd_addr_a !== 3'd0) begin n_fail++; $display("FAIL haz_release_M1: a=%0d want 0", o_rd_addr_a); end
`else
        n_checks++; if (o_rd_addr_a !== 3'd3 || o_rd_addr_b !== 3'd1) begin n_fail++; $display("FAIL haz_release_M1: a=%0d b=%0d want 3/1", o_rd_addr_a, o_rd_addr_b); end
`endif
        wait_valid();
        n_checks++; if (o_op_a !== 16'h0033 || o_op_b !== 16'h0011) begin n_fail++; $display("FAIL haz_ops: a=%h b=%h want 0033/0011", o_op_a, o_op_b); end
        n_checks++; if (dut.u_scoreboard.pend_q !== 8'h00) begin n_fail++; $display("FAIL haz_pend: pend=%b want 0", dut.u_scoreboard.pend_q); end
        tick();
    endtask

    task automatic test_flags_and_zero();
        issue(3'd5, 3'd6, 3'd0, WSEL_REGF);
        wait_valid();
        n_checks++; if (o_op_a !== 16'h0055 || o_op_b !== 16'h0066) begin n_fail++; $display("FAIL regf_ops: a=%h b=%h want 0055/0066", o_op_a, o_op_b); end
        n_checks++; if (dut.u_scoreboard.pend_q !== 8'h80) begin n_fail++; $display("FAIL regf_pend: pend=%b want 10000000", dut.u_scoreboard.pend_q); end
        tick();
        issue(3'd1, 3'd7, 3'd2, WSEL_NONE);
        tick(); tick();
        n_checks++; if (o_rd_addr_b !== 3'd0 || o_valid !== 1'b0) begin n_fail++; $display("FAIL regf_stall: b=%0d valid=%0b want 0/0", o_rd_addr_b, o_valid); end
        writeback(WSEL_REGF, 3'd0, 16'h0);
        tick();
        wb_idle();
        wait_valid();
        n_checks++; if (o_op_a !== 16'h0011 || o_op_b !== 16'h0077) begin n_fail++; $display("FAIL regf_ops2: a=%h b=%h want 0011/0077", o_op_a, o_op_b); end
        tick();
        issue(3'd0, 3'd0, 3'd0, WSEL_REGC);
        n_checks++; if (o_rd_addr_a !== 3'd0 || o_valid !== 1'b0) begin n_fail++; $display("FAIL zero_nostall: a=%0d valid=%0b want 0/0", o_rd_addr_a, o_valid); end
        tick(); tick();
        n_checks++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL zero_latency: o_valid=%0b want 1", o_valid); end
        n_checks++; if (o_op_a !== 16'h0000 || o_op_b !== 16'h0000) begin n_fail++; $display("FAIL zero_ops: a=%h b=%h want 0000/0000", o_op_a, o_op_b); end
        n_checks++; if (dut.u_scoreboard.pend_q !== 8'h00) begin n_fail++; $display("FAIL zero_pend: pend=%b want 0", dut.u_scoreboard.pend_q); end
        tick();
    endtask

    task automatic test_backpressure();
        i_ready = 1'b0;
        issue(3'd2, 3'd1, 3'd6, WSEL_NONE);
        wait_valid();
        for (int c = 0; c < 5; c++) begin
            n_checks++; if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_op_a !== 16'h0022 || o_op_b !== 16'h0011) begin n_fail++; $display("FAIL bp_hold[%0d]: valid=%0b ready=%0b a=%h b=%h want 1/0/0022/0011", c, o_valid, o_ready, o_op_a, o_op_b); end
            tick();
        end
        i_ready = 1'b1;
        tick();
        n_checks++; if (o_ready !== 1'b1 || o_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release: ready=%0b valid=%0b want 1/0", o_ready, o_valid); end
    endtask

    task automatic test_set_wins_and_bypass();
        issue(3'd2, 3'd1, 3'd4, WSEL_REGC);
        tick();
        writeback(WSEL_REGC, 3'd4, 16'h0);
        tick();
        wb_idle();
        n_checks++; if (dut.u_scoreboard.pend_q !== 8'h10) begin n_fail++; $display("FAIL set_wins: pend=%b want 00010000", dut.u_scoreboard.pend_q); end
        tick();
        writeback(WSEL_REGC, 3'd4, 16'h0);
        tick();
        wb_idle();
        n_checks++; if (dut.u_scoreboard.pend_q !== 8'h00) begin n_fail++; $display("FAIL clear4: pend=%b want 0", dut.u_scoreboard.pend_q); end
        issue(3'd2, 3'd6, 3'd0, WSEL_NONE);
        tick();
        writeback(WSEL_REGC, 3'd2, 16'hBEEF);
        tick();
        wb_idle();
`ifdef REGFILE_WB_BYPASS_EN
        n_checks++; if (o_op_a !== 16'hBEEF || o_op_b !== 16'h0066) begin n_fail++; $display("FAIL bypass_data: a=%h b=%h want BEEF/0066", o_op_a, o_op_b); end
`else
        n_checks++; if (o_op_a !== 16'h0022 || o_op_b !== 16'h0066) begin n_fail++; $display("FAIL bypass_data: a=%h b=%h want 0022/0066", o_op_a, o_op_b); end
`endif
        tick();
    endtask

    task automatic test_midop_reset_and_rfu();
        issue(3'd1, 3'd2, 3'd3, WSEL_REGC);
        wait_valid();
        tick();
        issue(3'd3, 3'd2, 3'd1, WSEL_REGC);
        tick();
        rst = 1'b1;
        #1;
        n_checks++; if (o_valid !== 1'b0 || o_ready !== 1'b0 || dut.u_scoreboard.pend_q !== 8'h00) begin n_fail++; $display("FAIL midrst: valid=%0b ready=%0b pend=%b want 0/0/0", o_valid, o_ready, dut.u_scoreboard.pend_q); end
        tick();
        rst = 1'b0;
        tick();
        n_checks++; if (o_ready !== 1'b1 || o_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_release: ready=%0b valid=%0b want 1/0", o_ready, o_valid); end
        writeback(WSEL_REGC, 3'd3, 16'h0);
        tick();
        wb_idle();
        n_checks++; if (dut.u_scoreboard.pend_q !== 8'h00 || o_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_wb_ignored: pend=%b ready=%0b want 0/1", dut.u_scoreboard.pend_q, o_ready); end
        n_checks++; if (o_err !== 1'b0) begin n_fail++; $display("FAIL rfu_pre: o_err=%0b want 0", o_err); end
        issue(3'd1, 3'd2, 3'd5, WSEL_RFU);
        n_checks++; if (o_err !== 1'b1) begin n_fail++; $display("FAIL rfu_pulse: o_err=%0b want 1", o_err); end
        tick();
        n_checks++; if (o_err !== 1'b0) begin n_fail++; $display("FAIL rfu_one_cycle: o_err=%0b want 0", o_err); end
        wait_valid();
        n_checks++; if (o_op_a !== 16'h0011 || dut.u_scoreboard.pend_q !== 8'h00) begin n_fail++; $display("FAIL rfu_as_none: a=%h pend=%b want 0011/0", o_op_a, dut.u_scoreboard.pend_q); end
        tick();
    endtask

    initial begin
        rf[0] = 16'hDEAD; rf[1] = 16'h0011; rf[2] = 16'h0022; rf[3] = 16'h0033;
        rf[4] = 16'h0044; rf[5] = 16'h0055; rf[6] = 16'h0066; rf[7] = 16'h0077;
        test_reset();
        test_basic();
        test_hazard_regc();
        test_flags_and_zero();
        test_backpressure();
        test_set_wins_and_bypass();
        test_midop_reset_and_rfu();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
